// File: rtl/apb_pkg.sv
// Shared APB definitions: FSM state encoding, default widths and timeout,
// and the command record carried from the request stream onto the bus.
package apb_pkg;

    localparam int APB_ADDR_W          = 32;
    localparam int APB_DATA_W          = 32;
    localparam int APB_DEFAULT_TIMEOUT = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

    typedef struct packed {
        logic [APB_ADDR_W-1:0] addr;
        logic                  write;
        logic [APB_DATA_W-1:0] wdata;
    } apb_cmd_t;

endpackage

// File: rtl/apb_timeout_counter.sv
// Counts ACCESS cycles that end without pready. The count saturates at
// TIMEOUT_CYCLES and never wraps. expired is high during the last ACCESS
// cycle the requester may still wait, so an abort on that edge gives
// exactly TIMEOUT_CYCLES ACCESS cycles.
module apb_timeout_counter
    import apb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = APB_DEFAULT_TIMEOUT
) (
    input  logic pclk,
    input  logic preset_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count;

    // Saturating up-count of stalled ACCESS cycles; clear has priority.
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != CNT_SAT)) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (count >= CNT_LAST);

endmodule

// File: rtl/apb_master_ctrl.sv
// APB requester: accepts one valid/ready command at a time, runs it as an
// APB SETUP/ACCESS transfer and returns one response per command. A hung
// slave is abandoned after TIMEOUT_CYCLES ACCESS cycles.
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   IDLE   | cmd_ready_o high, bus deselected, waiting for a command
//   SETUP  | psel_o high, penable_o low, one cycle only
//   ACCESS | psel_o and penable_o high, waiting for pready or timeout
module apb_master_ctrl
    import apb_pkg::*;
#(
    parameter int ADDR_W         = APB_ADDR_W,
    parameter int DATA_W         = APB_DATA_W,
    parameter int TIMEOUT_CYCLES = APB_DEFAULT_TIMEOUT
) (
    input  logic              pclk,
    input  logic              preset_n,

    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic [ADDR_W-1:0] cmd_addr_i,
    input  logic              cmd_write_i,
    input  logic [DATA_W-1:0] cmd_wdata_i,

    output logic              rsp_valid_o,
    output logic [DATA_W-1:0] rsp_rdata_o,
    output logic              rsp_timeout_o,

    output logic              psel_o,
    output logic              penable_o,
    output logic [ADDR_W-1:0] paddr_o,
    output logic              pwrite_o,
    output logic [DATA_W-1:0] pwdata_o,
    input  logic [DATA_W-1:0] prdata_i,
    input  logic              pready_i
);

    apb_state_e state;

    logic timeout_clear;
    logic timeout_enable;
    logic timeout_expired;

    // SETUP is always exactly one cycle, so clearing there arms the counter
    // for the first ACCESS cycle.
    assign timeout_clear  = (state == SETUP);
    assign timeout_enable = (state == ACCESS) && !pready_i;

    apb_timeout_counter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .pclk     (pclk),
        .preset_n (preset_n),
        .clear    (timeout_clear),
        .enable   (timeout_enable),
        .expired  (timeout_expired)
    );

    // Transfer FSM with every output registered.
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            state         <= IDLE;
            cmd_ready_o   <= 1'b0;
            rsp_valid_o   <= 1'b0;
            rsp_rdata_o   <= '0;
            rsp_timeout_o <= 1'b0;
            psel_o        <= 1'b0;
            penable_o     <= 1'b0;
            paddr_o       <= '0;
            pwrite_o      <= 1'b0;
            pwdata_o      <= '0;
        end else begin
            rsp_valid_o   <= 1'b0;
            rsp_timeout_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid_i && cmd_ready_o) begin
                        paddr_o     <= cmd_addr_i;
                        pwrite_o    <= cmd_write_i;
                        pwdata_o    <= cmd_wdata_i;
                        psel_o      <= 1'b1;
                        cmd_ready_o <= 1'b0;
                        state       <= SETUP;
                    end else begin
                        cmd_ready_o <= 1'b1;
                    end
                end
                SETUP: begin
                    penable_o <= 1'b1;
                    state     <= ACCESS;
                end
                ACCESS: begin
                    // pready on the final allowed cycle still counts as a
                    // normal completion.
                    if (pready_i || timeout_expired) begin
                        psel_o        <= 1'b0;
                        penable_o     <= 1'b0;
                        cmd_ready_o   <= 1'b1;
                        rsp_valid_o   <= 1'b1;
                        rsp_timeout_o <= !pready_i;
                        rsp_rdata_o   <= (pready_i && !pwrite_o) ? prdata_i : '0;
                        state         <= IDLE;
                    end
                end
                default: begin
                    psel_o    <= 1'b0;
                    penable_o <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule
